iterative_muldiv_unit: RTL and testbench

- Multi-cycle, parametrised successor to the single-cycle add/sub/compare arithmetic unit in the execute stage.
- Implements the RISC-V M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Uses a radix-2 shift-add multiplier and a restoring divider that share one datapath.
- Uses a start/busy/valid handshake so the pipeline can stall the execute stage while it runs.

---
 rtl/iterative_muldiv_unit_if.sv | 25 ++
 rtl/iterative_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_iterative_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_muldiv_unit_if.sv
// Start/busy/valid handshake bundle between the execute stage and the
// iterative multiply/divide unit.
interface iterative_muldiv_unit_if #(
    parameter int size = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [size-1:0] A;
    logic [size-1:0] B;
    logic            busy;
    logic            valid;
    logic [size-1:0] result;
    logic            div_by_zero;

    modport master (
        output start, flush, op, A, B,
        input  busy, valid, result, div_by_zero
    );

    modport slave (
        input  start, flush, op, A, B,
        output busy, valid, result, div_by_zero
    );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// RISC-V M-extension unit: radix-2 shift-add multiplier and restoring divider
// sharing one (size+2)-bit adder, one iteration per cycle.
module iterative_muldiv_unit #(
    parameter int size  = 32,
    parameter int CNT_W = $clog2(size) + 1
) (
    input logic                    clk,
    input logic                    reset,
    iterative_muldiv_unit_if.slave bus
);

    localparam logic [size-1:0]   ZERO     = {size{1'b0}};
    localparam logic [size-1:0]   ONES     = {size{1'b1}};
    localparam logic [size-1:0]   ONE      = {{(size-1){1'b0}}, 1'b1};
    localparam logic [size-1:0]   MINV     = {1'b1, {(size-1){1'b0}}};
    localparam logic [2*size-1:0] ONE2     = {{(2*size-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(size);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [size-1:0] neg_w(input logic [size-1:0] x);
        return ~x + ONE;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [size-1:0]   r_a;
    logic [size-1:0]   r_b;
    logic [2*size-1:0] r_acc;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_special;
    logic              r_dbz_pend;
    logic              r_busy;
    logic              r_valid;
    logic [size-1:0]   r_result;
    logic              r_dbz;

    logic              w_accept;
    logic              w_iterate;
    logic              w_finish;

    logic              w_is_div;
    logic              w_sa;
    logic              w_sb;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [size-1:0]   w_a_mag;
    logic [size-1:0]   w_b_mag;
    logic              w_dbz;
    logic              w_ovf;
    logic              w_special;
    logic [size-1:0]   w_special_val;
    logic [2*size-1:0] w_acc_init;

    logic [size:0]     w_op1;
    logic [size:0]     w_op2;
    logic              w_cin;
    logic [size+1:0]   w_sum;
    logic [2*size-1:0] w_acc_nxt;

    logic [2*size-1:0] w_prod;
    logic [size-1:0]   w_quo;
    logic [size-1:0]   w_rem;
    logic [size-1:0]   w_final;

    assign bus.busy        = r_busy;
    assign bus.valid       = r_valid;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dbz;

    // Operand decode on the accept cycle: magnitudes, signs and RISC-V special cases
    always_comb begin
        w_is_div = bus.op[2];
        if (w_is_div) begin
            w_sa = ~bus.op[0];
            w_sb = ~bus.op[0];
        end else begin
            w_sa = (bus.op[1:0] != 2'b11);
            w_sb = ~bus.op[1];
        end
        w_a_neg   = w_sa & bus.A[size-1];
        w_b_neg   = w_sb & bus.B[size-1];
        w_a_mag   = w_a_neg ? neg_w(bus.A) : bus.A;
        w_b_mag   = w_b_neg ? neg_w(bus.B) : bus.B;
        w_dbz     = w_is_div & (bus.B == ZERO);
        w_ovf     = w_is_div & ~bus.op[0] & (bus.A == MINV) & (bus.B == ONES);
        w_special = w_dbz | w_ovf;
        if (w_dbz) begin
            w_special_val = bus.op[1] ? bus.A : ONES;
        end else if (w_ovf) begin
            w_special_val = bus.op[1] ? ZERO : bus.A;
        end else begin
            w_special_val = ZERO;
        end
        // Special results ride in the low half of the accumulator to DONE
        if (w_special) begin
            w_acc_init = {ZERO, w_special_val};
        end else if (w_is_div) begin
            w_acc_init = {ZERO, w_a_mag};
        end else begin
            w_acc_init = {ZERO, w_b_mag};
        end
    end

    // Shared adder: add-multiplicand for multiply, trial-subtract divisor for divide
    always_comb begin
        if (r_op[2]) begin
            w_op1 = r_acc[2*size-1:size-1];
            w_op2 = ~{1'b0, r_b};
            w_cin = 1'b1;
        end else begin
            w_op1 = {1'b0, r_acc[2*size-1:size]};
            w_op2 = r_acc[0] ? {1'b0, r_a} : {1'b0, ZERO};
            w_cin = 1'b0;
        end
        w_sum = {1'b0, w_op1} + {1'b0, w_op2} + {{(size+1){1'b0}}, w_cin};
        if (r_op[2]) begin
            if (w_sum[size+1]) begin
                w_acc_nxt = {w_sum[size-1:0], r_acc[size-2:0], 1'b1};
            end else begin
                w_acc_nxt = {r_acc[2*size-2:size-1], r_acc[size-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = {w_sum[size:0], r_acc[size-1:1]};
        end
    end

    // Sign fix-up and result selection, consumed on the DONE exit edge
    always_comb begin
        w_prod = r_neg_res ? (~r_acc + ONE2) : r_acc;
        w_quo  = r_neg_res ? neg_w(r_acc[size-1:0]) : r_acc[size-1:0];
        w_rem  = r_neg_rem ? neg_w(r_acc[2*size-1:size]) : r_acc[2*size-1:size];
        if (r_special) begin
            w_final = r_acc[size-1:0];
        end else if (!r_op[2]) begin
            w_final = (r_op[1:0] == 2'b00) ? w_prod[size-1:0] : w_prod[2*size-1:size];
        end else if (!r_op[1]) begin
            w_final = w_quo;
        end else begin
            w_final = w_rem;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; flush wins over everything
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.start) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        w_accept  = 1'b0;
        w_iterate = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            S_IDLE:  w_accept  = bus.start & ~bus.flush;
            S_CALC:  w_iterate = ~bus.flush;
            S_DONE:  w_finish  = ~bus.flush;
            default: w_accept  = 1'b0;
        endcase
    end

    // Datapath registers: operand capture and per-cycle iteration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= {CNT_W{1'b0}};
            r_op       <= 3'b000;
            r_a        <= ZERO;
            r_b        <= ZERO;
            r_acc      <= {ZERO, ZERO};
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_special  <= 1'b0;
            r_dbz_pend <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= CNT_INIT;
            r_op       <= bus.op;
            r_a        <= w_a_mag;
            r_b        <= w_b_mag;
            r_acc      <= w_acc_init;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_special  <= w_special;
            r_dbz_pend <= w_dbz;
        end else if (w_iterate) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CNT_ONE;
        end else if (bus.flush) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Registered handshake outputs; result/div_by_zero hold between valid pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= ZERO;
            r_dbz    <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt == S_CALC);
            r_valid <= w_finish;
            if (w_finish) begin
                r_result <= w_final;
                r_dbz    <= r_dbz_pend;
            end else begin
                r_result <= r_result;
                r_dbz    <= r_dbz;
            end
        end
    end

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Bench for iterative_muldiv_unit: directed 32-bit table, multi-cycle corner
// sequences, and a 16-bit randomized run against an arithmetic reference model.
module tb_iterative_muldiv_unit;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    iterative_muldiv_unit_if #(.size(32)) if32 ();
    iterative_muldiv_unit_if #(.size(16)) if16 ();

    iterative_muldiv_unit #(.size(32)) u_dut32 (.clk(clk), .reset(reset), .bus(if32));
    iterative_muldiv_unit #(.size(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          poke;
        logic [31:0] exp_res;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the RISC-V rules using plain wide arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w,
                                           output logic dbz, output logic special);
        longint      mask, ua, ub, sa, sb, res, minv;
        logic [63:0] pu;
        mask = (longint'(1) << w) - longint'(1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = ua[w-1] ? ua - (mask + longint'(1)) : ua;
        sb   = ub[w-1] ? ub - (mask + longint'(1)) : ub;
        minv = -(longint'(1) << (w - 1));
        dbz     = op[2] && (ub == longint'(0));
        special = dbz || ((op == 3'd4 || op == 3'd6) && sa == minv && sb == -longint'(1));
        case (op)
            3'd0: res = sa * sb;
            3'd1: res = (sa * sb) >>> w;
            3'd2: res = (sa * ub) >>> w;
            3'd3: begin
                pu  = 64'(ua) * 64'(ub);
                res = longint'(pu >> w);
            end
            3'd4: res = dbz ? mask : (special ? sa : sa / sb);
            3'd5: res = dbz ? mask : ua / ub;
            3'd6: res = dbz ? ua : (special ? longint'(0) : sa % sb);
            default: res = dbz ? ua : ua % ub;
        endcase
        return 32'(res & mask);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where valid is seen.
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int poke, output logic [31:0] res, output logic dbz,
                           output int lat, output int nbusy);
        if32.start = 1'b1;
        if32.op    = op;
        if32.A     = a;
        if32.B     = b;
        @(negedge clk);
        lat   = 0;
        nbusy = 0;
        while (if32.valid !== 1'b1 && lat < 100) begin
            if32.start = (lat == poke);
            if32.op    = (lat == poke) ? 3'd5 : op;
            if32.A     = $urandom;
            if32.B     = $urandom;
            if (if32.busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        if32.start = 1'b0;
        res = if32.result;
        dbz = if32.div_by_zero;
        chk("busy_at_valid", {63'd0, if32.busy}, 64'd0);
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic dbz, output int lat);
        if16.start = 1'b1;
        if16.op    = op;
        if16.A     = a;
        if16.B     = b;
        @(negedge clk);
        if16.start = 1'b0;
        lat = 0;
        while (if16.valid !== 1'b1 && lat < 100) begin
            if16.A = 16'($urandom);
            if16.B = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        res = if16.result;
        dbz = if16.div_by_zero;
    endtask

    initial begin
        logic [31:0] res;
        logic [15:0] res16;
        logic        dbz;
        logic        edbz;
        logic        spec;
        logic [31:0] eres;
        logic [2:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat;
        int          nbusy;
        int          nvalid;

        n_chk = 0;
        n_err = 0;
        tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'd7,        -1, 32'hFFFFFFF9, 1'b0, 33};
        tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'd7,        -1, 32'hFFFFFFFF, 1'b0, 33};
        tbl[2]  = '{3'd3, 32'hFFFFFFFF, 32'd7,        -1, 32'h00000006, 1'b0, 33};
        tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'd7,        -1, 32'hFFFFFFFF, 1'b0, 33};
        tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        -1, 32'hFFFFFFFD, 1'b0, 33};
        tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        -1, 32'hFFFFFFFF, 1'b0, 33};
        tbl[6]  = '{3'd5, 32'd100,      32'd7,        -1, 32'd14,       1'b0, 33};
        tbl[7]  = '{3'd7, 32'd100,      32'd7,        -1, 32'd2,        1'b0, 33};
        tbl[8]  = '{3'd5, 32'h00001234, 32'd0,        -1, 32'hFFFFFFFF, 1'b1, 1};
        tbl[9]  = '{3'd6, 32'h00001234, 32'd0,        -1, 32'h00001234, 1'b1, 1};
        tbl[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, -1, 32'h80000000, 1'b0, 1};
        tbl[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, -1, 32'h00000000, 1'b0, 1};
        tbl[12] = '{3'd0, 32'd3,        32'd5,         4, 32'd15,       1'b0, 33};
        tbl[13] = '{3'd5, 32'h00001234, 32'd0,         0, 32'hFFFFFFFF, 1'b1, 1};
        tbl[14] = '{3'd0, 32'h00001234, 32'd0,        -1, 32'h00000000, 1'b0, 33};
        tbl[15] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'hFFFFFFFE, 1'b0, 33};
        tbl[16] = '{3'd1, 32'h80000000, 32'h80000000, -1, 32'h40000000, 1'b0, 33};
        tbl[17] = '{3'd7, 32'd5,        32'hFFFFFFFF, -1, 32'd5,        1'b0, 33};
        tbl[18] = '{3'd4, 32'd7,        32'hFFFFFFF9, -1, 32'hFFFFFFFF, 1'b0, 33};

        reset = 1'b1;
        if32.start = 1'b0; if32.flush = 1'b0; if32.op = 3'd0; if32.A = 32'd0; if32.B = 32'd0;
        if16.start = 1'b0; if16.flush = 1'b0; if16.op = 3'd0; if16.A = 16'd0; if16.B = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   {63'd0, if32.busy}, 64'd0);
        chk("rst_valid",  {63'd0, if32.valid}, 64'd0);
        chk("rst_result", {32'd0, if32.result}, 64'd0);
        chk("rst_dbz",    {63'd0, if32.div_by_zero}, 64'd0);
        chk("rst_result16", {48'd0, if16.result}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            issue32(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].poke, res, dbz, lat, nbusy);
            chk($sformatf("tbl%0d_result", i), {32'd0, res}, {32'd0, tbl[i].exp_res});
            chk($sformatf("tbl%0d_dbz", i), {63'd0, dbz}, {63'd0, tbl[i].exp_dbz});
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_busy_cycles", i), 64'(nbusy),
                (tbl[i].exp_lat == 1) ? 64'd0 : 64'd32);
        end

        // Flush at CALC cycle 5: busy drops, no valid, result holds the last value.
        if32.start = 1'b1; if32.op = 3'd5; if32.A = 32'd1000; if32.B = 32'd3;
        @(negedge clk);
        if32.start = 1'b0;
        repeat (4) @(negedge clk);
        if32.flush = 1'b1;
        @(negedge clk);
        if32.flush = 1'b0;
        chk("flush_busy", {63'd0, if32.busy}, 64'd0);
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if32.valid === 1'b1) nvalid++;
        end
        chk("flush_no_valid", 64'(nvalid), 64'd0);
        chk("flush_result_held", {32'd0, if32.result}, {32'd0, tbl[18].exp_res});

        // start and flush together in IDLE: nothing is accepted.
        if32.start = 1'b1; if32.flush = 1'b1; if32.op = 3'd4; if32.A = 32'd50; if32.B = 32'd5;
        @(negedge clk);
        if32.start = 1'b0; if32.flush = 1'b0;
        chk("startflush_busy", {63'd0, if32.busy}, 64'd0);
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if32.valid === 1'b1) nvalid++;
        end
        chk("startflush_no_valid", 64'(nvalid), 64'd0);

        // Asynchronous reset at CALC cycle 10 of a DIV.
        if32.start = 1'b1; if32.op = 3'd4; if32.A = 32'hFFFFFFF9; if32.B = 32'd2;
        @(negedge clk);
        if32.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midcalc_busy", {63'd0, if32.busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy",   {63'd0, if32.busy}, 64'd0);
        chk("async_rst_valid",  {63'd0, if32.valid}, 64'd0);
        chk("async_rst_result", {32'd0, if32.result}, 64'd0);
        chk("async_rst_dbz",    {63'd0, if32.div_by_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if32.valid === 1'b1) nvalid++;
        end
        chk("post_rst_no_valid", 64'(nvalid), 64'd0);
        issue32(3'd5, 32'd100, 32'd7, -1, res, dbz, lat, nbusy);
        chk("post_rst_result", {32'd0, res}, 64'd14);
        chk("post_rst_latency", 64'(lat), 64'd33);

        // 16-bit randomized regression, back-to-back issue.
        for (int i = 0; i < 1000; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            case ($urandom_range(0, 15))
                0, 1:    rb = 16'h0000;
                2:       begin ra = 16'h8000; rb = 16'hFFFF; end
                3:       rb = 16'hFFFF;
                default: rb = rb;
            endcase
            eres = ref_op(rop, {16'd0, ra}, {16'd0, rb}, 16, edbz, spec);
            issue16(rop, ra, rb, res16, dbz, lat);
            chk($sformatf("rand%0d_op%0d_result", i, rop), {48'd0, res16}, {32'd0, eres});
            chk($sformatf("rand%0d_op%0d_dbz", i, rop), {63'd0, dbz}, {63'd0, edbz});
            chk($sformatf("rand%0d_op%0d_latency", i, rop), 64'(lat), spec ? 64'd1 : 64'd17);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
